// File: rtl/rf_port_arbiter_if.sv
// rf_port_arbiter_if: execution-unit request/response bus plus register-file port
interface rf_port_arbiter_if #(
    parameter int EU_NUM    = 8,
    parameter int RF_ADDR_W = 10,
    parameter int RF_DATA_W = 1408
);
    logic [EU_NUM-1:0]                req_valid;
    logic [EU_NUM-1:0]                req_we;
    logic [EU_NUM-1:0]                req_lock;
    logic [EU_NUM-1:0][RF_ADDR_W-1:0] req_addr;
    logic [EU_NUM-1:0][RF_DATA_W-1:0] req_data;
    logic [EU_NUM-1:0]                req_ready;
    logic [EU_NUM-1:0]                rsp_valid;
    logic [RF_DATA_W-1:0]             rsp_data;
    logic [RF_ADDR_W-1:0]             rf_addr;
    logic                             rf_we;
    logic                             rf_re;
    logic [RF_DATA_W-1:0]             rf_d;
    logic [RF_DATA_W-1:0]             rf_q;
    modport master (
        output req_valid, req_we, req_lock, req_addr, req_data, rf_q,
        input  req_ready, rsp_valid, rsp_data, rf_addr, rf_we, rf_re, rf_d
    );
    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_data, rf_q,
        output req_ready, rsp_valid, rsp_data, rf_addr, rf_we, rf_re, rf_d
    );
endinterface

// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter: round-robin register-file port arbiter with bounded burst locking
module rf_port_arbiter #(
    parameter int EU_NUM    = 8,
    parameter int RF_ADDR_W = 10,
    parameter int RF_DATA_W = 1408,
    parameter int LOCK_MAX  = 4
) (
    input logic clk,
    input logic rst,
    rf_port_arbiter_if.slave bus
);
    localparam int PW = EU_NUM > 1 ? $clog2(EU_NUM) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t            state;
    logic [PW-1:0]     rr_ptr, owner, start, rr_idx, gnt_idx;
    logic [CW-1:0]     beat_cnt;
    logic              rr_any, hold, gnt_any;
    logic [EU_NUM-1:0] gnt_oh, rsp_valid;
    int                j;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(EU_NUM - 1)) ? '0 : p + 1'b1;
    endfunction
    // A locked owner that goes idle falls back to round-robin from the slot after it
    assign start = (state == LOCKED) ? nxt(owner) : rr_ptr;
    assign hold  = (state == LOCKED) && bus.req_valid[owner];
    always_comb begin
        rr_any = 1'b0;
        rr_idx = '0;
        j = 0;
        for (int k = EU_NUM - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= EU_NUM) j -= EU_NUM;
            if (bus.req_valid[j]) begin
                rr_any = 1'b1;
                rr_idx = PW'(j);
            end
        end
    end
    assign gnt_any       = ~rst & (hold | rr_any);
    assign gnt_idx       = hold ? owner : rr_idx;
    assign gnt_oh        = gnt_any ? (EU_NUM'(1) << gnt_idx) : '0;
    assign bus.req_ready = gnt_oh;
    assign bus.rf_addr   = gnt_any ? bus.req_addr[gnt_idx] : '0;
    assign bus.rf_d      = gnt_any ? bus.req_data[gnt_idx] : '0;
    assign bus.rf_we     = gnt_any & bus.req_we[gnt_idx];
    assign bus.rf_re     = gnt_any & ~bus.req_we[gnt_idx];
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_data  = |rsp_valid ? bus.rf_q : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            rsp_valid <= '0;
        end else begin
            rsp_valid <= bus.rf_re ? gnt_oh : '0;
            if (hold) begin
                if (beat_cnt + 1'b1 == CW'(LOCK_MAX) || !bus.req_lock[owner]) begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                    rr_ptr   <= nxt(owner);
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end else if (gnt_any) begin
                if (bus.req_lock[gnt_idx] && LOCK_MAX > 1) begin
                    state    <= LOCKED;
                    owner    <= gnt_idx;
                    beat_cnt <= CW'(1);
                end else begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                    rr_ptr   <= nxt(gnt_idx);
                end
            end else if (state == LOCKED) begin
                state    <= IDLE;
                beat_cnt <= '0;
                rr_ptr   <= nxt(owner);
            end
        end
    end
endmodule

// File: tb/tb_rf_port_arbiter.sv
// tb_rf_port_arbiter: directed checks of grant order, locking, read path and reset
module tb_rf_port_arbiter;
    localparam int EU = 8, AW = 10, DW = 1408, LM = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0, n_err = 0;
    logic [DW-1:0] mem [16];
    always #5 clk = ~clk;
    rf_port_arbiter_if #(.EU_NUM(EU), .RF_ADDR_W(AW), .RF_DATA_W(DW)) bus ();
    rf_port_arbiter #(.EU_NUM(EU), .RF_ADDR_W(AW), .RF_DATA_W(DW), .LOCK_MAX(LM)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    function automatic logic [DW-1:0] pat(input int k);
        return {176{8'(k) + 8'h10}};
    endfunction
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= pat(i);
            bus.rf_q <= '0;
        end else begin
            if (bus.rf_we) mem[bus.rf_addr[3:0]] <= bus.rf_d;
            bus.rf_q <= bus.rf_re ? mem[bus.rf_addr[3:0]] : '0;
        end
    end
    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (low 64 bits)", tag, got[63:0], exp[63:0]);
        end
    endtask
    task automatic drive(input logic [EU-1:0] v, input logic [EU-1:0] w, input logic [EU-1:0] l);
        bus.req_valid = v;
        bus.req_we    = w;
        bus.req_lock  = l;
    endtask
    initial begin
        drive('0, '0, '0);
        bus.req_data = '0;
        for (int k = 0; k < EU; k++) bus.req_addr[k] = AW'(k);
        repeat (2) @(negedge clk);
        drive('1, '0, '0);
        #1;
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rf_re", bus.rf_re, 0);
        chk("rst_rf_addr", bus.rf_addr, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < EU; k++) begin
            #1;
            chk("rr_ready", bus.req_ready, EU'(1) << k);
            chk("rr_addr", bus.rf_addr, k);
            @(negedge clk);
            chk("rr_rsp_valid", bus.rsp_valid, EU'(1) << k);
            chk("rr_rsp_data", bus.rsp_data, pat(k));
        end
        bus.req_addr[3] = AW'(5);
        bus.req_data[3] = {176{8'hA5}};
        drive(8'h08, 8'h08, 8'h00);
        #1;
        chk("wr_ready", bus.req_ready, 8'h08);
        chk("wr_we", bus.rf_we, 1);
        chk("wr_addr", bus.rf_addr, 5);
        chk("wr_d", bus.rf_d, {176{8'hA5}});
        @(negedge clk);
        chk("wr_no_rsp", bus.rsp_valid, 0);
        drive(8'h08, 8'h00, 8'h00);
        #1;
        chk("rd_ready", bus.req_ready, 8'h08);
        chk("rd_re", bus.rf_re, 1);
        @(negedge clk);
        chk("raw_rsp_valid", bus.rsp_valid, 8'h08);
        chk("raw_rsp_data", bus.rsp_data, {176{8'hA5}});
        drive(8'h80, 8'h00, 8'h00);
        #1;
        chk("wrap_7", bus.req_ready, 8'h80);
        @(negedge clk);
        drive(8'h01, 8'h00, 8'h00);
        #1;
        chk("wrap_0", bus.req_ready, 8'h01);
        @(negedge clk);
        drive(8'h24, 8'h00, 8'h04);
        for (int b = 0; b < LM; b++) begin
            #1;
            chk("lock_beat", bus.req_ready, 8'h04);
            @(negedge clk);
        end
        #1;
        chk("lock_release", bus.req_ready, 8'h20);
        @(negedge clk);
        drive(8'h1A, 8'h00, 8'h02);
        #1;
        chk("lk1_beat1", bus.req_ready, 8'h02);
        @(negedge clk);
        drive(8'h1B, 8'h00, 8'h00);
        #1;
        chk("lk1_beat2", bus.req_ready, 8'h02);
        @(negedge clk);
        #1;
        chk("lk1_next", bus.req_ready, 8'h08);
        @(negedge clk);
        drive(8'h40, 8'h00, 8'h00);
        #1;
        chk("pre_rst_ready", bus.req_ready, 8'h40);
        @(negedge clk);
        rst = 1'b1;
        drive(8'h44, 8'h00, 8'h00);
        #1;
        chk("rst_drop_rsp", bus.rsp_valid, 0);
        chk("rst_gate_ready", bus.req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_rsp", bus.rsp_valid, 0);
        #1;
        chk("post_rst_ready", bus.req_ready, 8'h04);
        @(negedge clk);
        chk("post_rst_rsp_valid", bus.rsp_valid, 8'h04);
        chk("post_rst_rsp_data", bus.rsp_data, pat(2));
        drive('0, '0, '0);
        @(negedge clk);
        chk("idle_rsp", bus.rsp_valid, 0);
        chk("idle_rf_re", bus.rf_re, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
